fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RISC-V core: holds the PC, drives the word address into the combinational instruction memory, and captures the returned instruction with its PC.
- Delivers fetched instructions to decode through a 2-entry valid/ready buffer, so decode stalls cost no refetch.
- Accepts branch/jump redirects from execute, which flush all in-flight fetches.

Parameters:
- ADDR_W, 6, instruction-memory word-address width; imem_addr = pc[ADDR_W+1:2].
- RESET_PC, 32'h0000_0004, PC value loaded on reset; word 0 of instruction memory is a dummy.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  ADDR_W  word address to instruction memory, equal to pc[ADDR_W+1:2].
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  byte target for the redirect.
- id_valid  out  1  buffer head holds a valid instruction.
- id_ready  in  1  decode accepts the head this cycle.
- id_inst  out  32  head instruction.
- id_pc  out  32  head PC.
- id_pc_plus4  out  32  id_pc + 4, mod 2^32.
- misalign_err  out  1  one-cycle pulse after a redirect with redirect_pc[1:0] != 0.

Behaviour:
- Reset: asserted asynchronously at any time, including mid-stall or mid-redirect.
  - pc = RESET_PC, count = 0, id_valid = 0, misalign_err = 0.
  - id_inst, id_pc and id_pc_plus4 = 0.
  - All buffer entries are invalidated.
- Memory interface: imem is combinational, so imem_data is sampled at the same edge that advances pc.
- Buffer: 2-entry FIFO of {pc, inst}; count ranges over 0..2. Head entry drives the id_* outputs; id_valid = (count != 0).
- pop = id_valid & id_ready.
- push = !redirect_valid & (count < 2 | pop); on push, entry {pc, imem_data} is written and pc <= pc + 4, with 32-bit wrap.
- No push: pc holds, and imem_addr is stable across the stall.
- Simultaneous push and pop:
  - count unchanged; head advances.
  - At count = 2 with pop, the freed slot is refilled in the same cycle, so there is no bubble.
- Redirect has priority over push and pop:
  - count <= 0, and any pop in that cycle is discarded.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - misalign_err <= (redirect_pc[1:0] != 0); otherwise misalign_err is 0 every cycle.
- Latency:
  - PC to id_valid: 1 cycle.
  - Redirect to first redirected instruction on id_*: 2 edges, giving exactly 1 bubble cycle.
  - Back-to-back redirects: only the last one takes effect.
- Address aliasing: imem_addr wraps from 2^ADDR_W-1 to 0 when pc crosses a 4*2^ADDR_W byte boundary; pc itself keeps counting.
- No state machine beyond the count/pc registers; all outputs are registered except id_pc_plus4, which is a combinational add on the head PC.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [15:0].
  - Increments every cycle with id_valid=1 and id_ready=0, saturating at 16'hFFFF.
  - Cleared only by rst_n; unaffected by redirect.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, id_ready=1, memory word n = n:
  - edge 0: imem_addr = 1.
  - edge 1: id_valid = 1, id_pc = 4, id_pc_plus4 = 8, id_inst = 1.
  - Then one instruction per cycle: id_pc = 8, 12, ...
- Backpressure:
  - Drive id_ready=0 for 5 cycles: count reaches 2 with entries at PC 4 and 8; imem_addr holds 3; id_pc holds 4.
  - Raise id_ready: id_pc = 4, 8, 12 on consecutive cycles, no bubble.
  - With FETCH_STALL_CNT_EN defined, stall_cnt = 5.
- Redirect to 0x44 while the buffer is full:
  - next cycle: id_valid = 0, imem_addr = 0x11.
  - following cycle: id_valid = 1, id_pc = 0x44.
- Redirect to 0x46: pc becomes 0x44; misalign_err = 1 for exactly one cycle, then 0.
- Redirect and pop in the same cycle at count = 1: the popped entry is not refetched, count = 0, and the next delivered id_pc = redirect target.
- Wrap, with RESET_PC=0xFC and ADDR_W=6: imem_addr sequence 63, 0, 1 while id_pc = 0xFC, 0x100, 0x104.
- Reset mid-operation: pull rst_n low asynchronously with count = 2 → id_valid drops before the next edge; after release, id_pc = RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, combinational imem addressing and a 2-entry
// {pc, inst} skid buffer toward decode. Optional stall counter under FETCH_STALL_CNT_EN.
module fetch_stage #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0004
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_inst,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc_plus4,
  output logic              misalign_err
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  logic [31:0] pc;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic [31:0] slot0_pc;
  logic [31:0] slot0_inst;
  logic [31:0] slot1_pc;
  logic [31:0] slot1_inst;
  logic        pop;
  logic        push;

  assign imem_addr   = pc[ADDR_W+1:2];
  assign id_pc       = slot0_pc;
  assign id_inst     = slot0_inst;
  // Gated so the plus-4 output reads zero while the buffer is empty (including reset).
  assign id_pc_plus4 = id_valid ? (slot0_pc + 32'd4) : 32'd0;

  // Handshake decode and next occupancy; a redirect empties the buffer.
  always_comb begin
    pop        = id_valid & id_ready;
    push       = !redirect_valid & ((count < 2'd2) | pop);
    count_next = count;
    if (redirect_valid) begin
      count_next = 2'd0;
    end else if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end else begin
      count_next = count;
    end
  end

  // PC, buffer occupancy, entry shifting and misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      count        <= 2'd0;
      id_valid     <= 1'b0;
      misalign_err <= 1'b0;
      slot0_pc     <= 32'd0;
      slot0_inst   <= 32'd0;
      slot1_pc     <= 32'd0;
      slot1_inst   <= 32'd0;
    end else begin
      misalign_err <= redirect_valid & (redirect_pc[1:0] != 2'b00);
      count        <= count_next;
      id_valid     <= (count_next != 2'd0);
      if (redirect_valid) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (push) begin
        pc <= pc + 32'd4;
      end else begin
        pc <= pc;
      end
      if (!redirect_valid) begin
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              slot0_pc   <= pc;
              slot0_inst <= imem_data;
            end else begin
              slot1_pc   <= pc;
              slot1_inst <= imem_data;
            end
          end
          2'b01: begin
            slot0_pc   <= slot1_pc;
            slot0_inst <= slot1_inst;
          end
          2'b11: begin
            // With a full buffer the freed slot is refilled on the same edge.
            if (count == 2'd1) begin
              slot0_pc   <= pc;
              slot0_inst <= imem_data;
            end else begin
              slot0_pc   <= slot1_pc;
              slot0_inst <= slot1_inst;
              slot1_pc   <= pc;
              slot1_inst <= imem_data;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  // Saturating count of cycles where decode holds off a valid instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (id_valid && !id_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory word n holds value n. A second instance with
// RESET_PC = 0xFC exercises imem_addr aliasing.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        misalign_err;

  logic [5:0]  w_addr;
  logic [31:0] w_data;
  logic        w_rv = 1'b0;
  logic [31:0] w_rpc = 32'd0;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic        w_mis;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] w_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_data = 32'(imem_addr);
  assign w_data    = 32'(w_addr);

  fetch_stage #(.ADDR_W(6), .RESET_PC(32'h0000_0004)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .misalign_err(misalign_err)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  fetch_stage #(.ADDR_W(6), .RESET_PC(32'h0000_00FC)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_data(w_data),
    .redirect_valid(w_rv), .redirect_pc(w_rpc),
    .id_valid(w_valid), .id_ready(w_ready), .id_inst(w_inst), .id_pc(w_pc),
    .id_pc_plus4(w_pc_plus4), .misalign_err(w_mis)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(w_stall_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    tick();
    tick();

    // Reset state
    check_val("rst_valid", 32'(id_valid), 32'd0);
    check_val("rst_pc", id_pc, 32'd0);
    check_val("rst_inst", id_inst, 32'd0);
    check_val("rst_plus4", id_pc_plus4, 32'd0);
    check_val("rst_mis", 32'(misalign_err), 32'd0);
    check_val("rst_addr", 32'(imem_addr), 32'd1);
    check_val("w_rst_addr", 32'(w_addr), 32'd63);
`ifdef FETCH_STALL_CNT_EN
    check_val("rst_stall", 32'(stall_cnt), 32'd0);
`endif
    rst_n = 1'b1;

    // Edge 1: first instruction appears
    tick();
    check_val("e1_valid", 32'(id_valid), 32'd1);
    check_val("e1_pc", id_pc, 32'd4);
    check_val("e1_plus4", id_pc_plus4, 32'd8);
    check_val("e1_inst", id_inst, 32'd1);
    check_val("e1_addr", 32'(imem_addr), 32'd2);
    check_val("w1_pc", w_pc, 32'h0000_00FC);
    check_val("w1_inst", w_inst, 32'd63);
    check_val("w1_addr", 32'(w_addr), 32'd0);

    // Backpressure for 5 edges
    id_ready = 1'b0;
    tick();
    check_val("w2_pc", w_pc, 32'h0000_0100);
    check_val("w2_inst", w_inst, 32'd0);
    check_val("w2_addr", 32'(w_addr), 32'd1);
    tick();
    check_val("w3_pc", w_pc, 32'h0000_0104);
    check_val("w3_inst", w_inst, 32'd1);
    check_val("w3_plus4", w_pc_plus4, 32'h0000_0108);
    tick();
    tick();
    tick();
    check_val("bp_valid", 32'(id_valid), 32'd1);
    check_val("bp_pc", id_pc, 32'd4);
    check_val("bp_inst", id_inst, 32'd1);
    check_val("bp_addr", 32'(imem_addr), 32'd3);
`ifdef FETCH_STALL_CNT_EN
    check_val("bp_stall", 32'(stall_cnt), 32'd5);
`endif

    // Release: drain without bubble
    id_ready = 1'b1;
    tick();
    check_val("rel1_pc", id_pc, 32'd8);
    check_val("rel1_inst", id_inst, 32'd2);
    tick();
    check_val("rel2_valid", 32'(id_valid), 32'd1);
    check_val("rel2_pc", id_pc, 32'd12);
    tick();
    check_val("rel3_pc", id_pc, 32'd16);
    check_val("rel3_addr", 32'(imem_addr), 32'd6);

    // Redirect to 0x44 with a full buffer
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0044;
    tick();
    check_val("rd_valid", 32'(id_valid), 32'd0);
    check_val("rd_addr", 32'(imem_addr), 32'h11);
    check_val("rd_mis", 32'(misalign_err), 32'd0);
    redirect_valid = 1'b0;
    tick();
    check_val("rd2_valid", 32'(id_valid), 32'd1);
    check_val("rd2_pc", id_pc, 32'h0000_0044);
    check_val("rd2_inst", id_inst, 32'h11);
    check_val("rd2_plus4", id_pc_plus4, 32'h0000_0048);
`ifdef FETCH_STALL_CNT_EN
    check_val("rd2_stall", 32'(stall_cnt), 32'd5);
`endif

    // Misaligned redirect to 0x46
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0046;
    tick();
    check_val("mis_pulse", 32'(misalign_err), 32'd1);
    check_val("mis_addr", 32'(imem_addr), 32'h11);
    redirect_valid = 1'b0;
    tick();
    check_val("mis_clear", 32'(misalign_err), 32'd0);
    check_val("mis_pc", id_pc, 32'h0000_0044);

    // Redirect together with a pop at count 1
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0080;
    tick();
    check_val("rp_valid", 32'(id_valid), 32'd0);
    check_val("rp_addr", 32'(imem_addr), 32'h20);
    redirect_valid = 1'b0;
    tick();
    check_val("rp_pc", id_pc, 32'h0000_0080);
    check_val("rp_inst", id_inst, 32'h20);

    // Back-to-back redirects: last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0010;
    tick();
    redirect_pc    = 32'h0000_0020;
    tick();
    check_val("bb_valid", 32'(id_valid), 32'd0);
    check_val("bb_addr", 32'(imem_addr), 32'd8);
    redirect_valid = 1'b0;
    tick();
    check_val("bb_pc", id_pc, 32'h0000_0020);
    check_val("bb_inst", id_inst, 32'd8);

    // Fill to count 2, then asynchronous reset between edges
    id_ready = 1'b0;
    tick();
    check_val("mr_pc", id_pc, 32'h0000_0020);
    check_val("mr_addr", 32'(imem_addr), 32'h0A);
`ifdef FETCH_STALL_CNT_EN
    check_val("mr_stall", 32'(stall_cnt), 32'd6);
`endif
    #3;
    rst_n = 1'b0;
    #1;
    check_val("ar_valid", 32'(id_valid), 32'd0);
    check_val("ar_pc", id_pc, 32'd0);
    check_val("ar_addr", 32'(imem_addr), 32'd1);
`ifdef FETCH_STALL_CNT_EN
    check_val("ar_stall", 32'(stall_cnt), 32'd0);
`endif
    #1;
    rst_n    = 1'b1;
    id_ready = 1'b1;
    tick();
    check_val("ar2_valid", 32'(id_valid), 32'd1);
    check_val("ar2_pc", id_pc, 32'd4);
    check_val("ar2_inst", id_inst, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
